// File: rtl/div_unsigned_32x20_pkg.sv
// Shared Calc_G definitions for the 32x20 divider: widths, FSM encoding and
// the fixed results returned for a zero divisor.
package div_unsigned_32x20_pkg;

    localparam int DW   = 32;
    localparam int VW   = 20;
    localparam int FRAC = 12;
    localparam int CW   = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    // Q20.12 representation of 1.0, shared with mult_unsigned_32x20.
    localparam logic [DW-1:0] Q_ONE         = 32'h0000_1000;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, then
// subtract the divisor when the shifted partial remainder is large enough.
module div_restore_step
    import div_unsigned_32x20_pkg::*;
(
    input  logic [VW:0]   prem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   prem_o,
    output logic          qbit_o
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;

    // The borrow out of the extra top bit of diff is the "shifted < divisor" flag.
    always_comb begin
        shifted = {prem_i, bit_i};
        diff    = shifted - {2'b00, divisor_i};
        qbit_o  = ~diff[VW+1];
        prem_o  = qbit_o ? diff[VW:0] : shifted[VW:0];
    end

endmodule

// File: rtl/div_unsigned_32x20.sv
// Sequential restoring divider: Q20.12 dividend / 20-bit integer divisor,
// one quotient bit per clock, with a fast path for a zero divisor.
module div_unsigned_32x20
    import div_unsigned_32x20_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] acc_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   prem_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic          dz_q;

    logic [VW:0]   prem_d;
    logic          qbit_d;
    logic [DW-1:0] acc_d;

    div_restore_step u_step (
        .prem_i    (prem_q),
        .bit_i     (acc_q[DW-1]),
        .divisor_i (dvs_q),
        .prem_o    (prem_d),
        .qbit_o    (qbit_d)
    );

    // Dividend bits leave the top of acc_q while quotient bits enter the bottom.
    assign acc_d = {acc_q[DW-2:0], qbit_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= dividend;
                        dvs_q   <= divisor;
                        prem_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (divisor == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    acc_q  <= acc_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW-1)) begin
                        quo_q   <= acc_d;
                        rem_q   <= prem_d[VW-1:0];
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Still busy here only on the zero-divisor path, which
                    // publishes its fixed result one cycle after acceptance.
                    if (busy_q) begin
                        quo_q  <= DIV0_QUOTIENT;
                        rem_q  <= '0;
                        dz_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_unsigned_32x20.sv
// Directed bench for div_unsigned_32x20: table of hand-computed divisions plus
// handshake, throughput and reset sequences.
module tb_div_unsigned_32x20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [19:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [19:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unsigned_32x20 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [19:0] b;
        logic [31:0] q;
        logic [19:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic launch(input logic [31:0] a, input logic [19:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_hi);
        lat     = 0;
        busy_hi = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bh;
        int n;
        int seen;

        vecs[0] = '{32'h0004_D04D, 20'd3,       32'h0001_9AC4, 20'd1,       1'b0};
        vecs[1] = '{32'h0007_B1C8, 20'd50,      32'h0000_2765, 20'd14,      1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 20'hFFFFF,   32'h0000_1000, 20'h00FFF,   1'b0};
        vecs[3] = '{32'h0000_1002, 20'd1,       32'h0000_1002, 20'd0,       1'b0};
        vecs[4] = '{32'h0004_D04D, 20'd0,       32'hFFFF_FFFF, 20'd0,       1'b1};
        vecs[5] = '{32'h0000_0064, 20'd10,      32'h0000_000A, 20'd0,       1'b0};
        vecs[6] = '{32'h0000_0000, 20'd7,       32'h0000_0000, 20'd0,       1'b0};
        vecs[7] = '{32'h0000_0005, 20'd10,      32'h0000_0000, 20'd5,       1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 20'd1,       32'hFFFF_FFFF, 20'd0,       1'b0};
        vecs[9] = '{32'h1234_5678, 20'h80000,   32'h0000_0246, 20'h45678,   1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dz", div_by_zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy_start", i), busy, 1);
            wait_done(lat, bh);
            chk($sformatf("v%0d_latency", i), lat, (vecs[i].b == 0) ? 1 : 32);
            chk($sformatf("v%0d_busy_until_done", i), bh, lat);
            chk($sformatf("v%0d_busy_with_done", i), busy, 0);
            chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            chk($sformatf("v%0d_dz", i), div_by_zero, vecs[i].dz);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
        end

        // A start mid-division must not disturb the running operands.
        launch(32'h0004_D04D, 20'd3);
        repeat (9) @(negedge clk);
        dividend = 32'h0007_B1C8;
        divisor  = 20'd50;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bh);
        chk("midstart_quotient", quotient, 32'h0001_9AC4);
        chk("midstart_remainder", remainder, 1);

        // A start in the DONE cycle is dropped.
        dividend = 32'h0000_1002;
        divisor  = 20'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("donestart_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("donestart_busy_later", busy, 0);
        chk("donestart_quotient", quotient, 32'h0001_9AC4);

        // Start held high: back-to-back divisions every 34 cycles.
        @(negedge clk);
        dividend = 32'h0007_B1C8;
        divisor  = 20'd50;
        start    = 1'b1;
        wait_done(lat, bh);
        chk("held_quotient", quotient, 32'h0000_2765);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 100);
        start = 1'b0;
        chk("held_period", n, 34);
        chk("held_quotient2", quotient, 32'h0000_2765);
        repeat (2) @(negedge clk);

        // Reset during CALC aborts the division.
        launch(32'hFFFF_FFFF, 20'hFFFFF);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        launch(32'h0000_0064, 20'd10);
        wait_done(lat, bh);
        chk("post_reset_latency", lat, 32);
        chk("post_reset_quotient", quotient, 32'h0000_000A);
        chk("post_reset_remainder", remainder, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
